// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and FSM encoding for the mem_responder block.
package mem_map_pkg;

   localparam int          DEPTH    = 64;
   localparam int          AW       = 6;
   localparam logic [15:0] LED_ADDR = 16'h1000;
   localparam logic [15:0] SW_ADDR  = 16'h2000;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } state_t;

   // True when the data address falls inside the RAM window (upper bits all zero).
   function automatic logic is_ram_addr(input logic [15:0] addr);
      return (addr[15:AW] == '0);
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Processor bus (fetch + load/store) and program-loader handshake.
interface mem_responder_if;
   import mem_map_pkg::*;

   logic [AW-1:0] pc;
   logic [15:0]   DIN;
   logic [15:0]   addrM;
   logic [15:0]   doutM;
   logic          wM;
   logic [15:0]   mem;
   logic          Run;
   logic          load_valid;
   logic [15:0]   load_data;
   logic          load_last;
   logic          load_ready;

   modport slave (
      input  pc, addrM, doutM, wM, load_valid, load_data, load_last,
      output DIN, mem, Run, load_ready
   );

   modport master (
      output pc, addrM, doutM, wM, load_valid, load_data, load_last,
      input  DIN, mem, Run, load_ready
   );

endinterface

// File: rtl/ram64x16.sv
// 64x16 storage: one synchronous write port, two asynchronous read ports
// (instruction fetch and data load). Reads show the old word until the edge.
module ram64x16 #(
   parameter int DEPTH = mem_map_pkg::DEPTH
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [mem_map_pkg::AW-1:0] waddr,
   input  logic [15:0]               wdata,
   input  logic [mem_map_pkg::AW-1:0] raddr_fetch,
   output logic [15:0]               rdata_fetch,
   input  logic [mem_map_pkg::AW-1:0] raddr_data,
   output logic [15:0]               rdata_data
);
   logic [15:0] ram_mem [DEPTH];

   // Single write port; no reset so the array maps onto plain storage.
   always_ff @(posedge clk) begin
      if (we) begin
         ram_mem[waddr] <= wdata;
      end
   end

   assign rdata_fetch = ram_mem[raddr_fetch];
   assign rdata_data  = ram_mem[raddr_data];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: clears RAM after reset, accepts a program image over the
// loader handshake, then serves instruction fetches, loads and stores with a
// small memory map (RAM window, LED register, switch inputs).
module mem_responder #(
   parameter int          DEPTH    = mem_map_pkg::DEPTH,
   parameter logic [15:0] LED_ADDR = mem_map_pkg::LED_ADDR,
   parameter logic [15:0] SW_ADDR  = mem_map_pkg::SW_ADDR
) (
   input  logic              Clock,
   input  logic              Resetn,   // active-high synchronous reset
   mem_responder_if.slave    bus,
   input  logic [9:0]        SW,
   output logic [15:0]       LEDR,
   output logic              wr_err
);
   import mem_map_pkg::*;

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_t          state_reg, state_next;
   logic [AW-1:0]   clr_idx_reg, clr_idx_next;
   logic [AW-1:0]   load_ptr_reg, load_ptr_next;
   logic            run_reg;
   logic [15:0]     led_reg, led_next;
   logic            err_reg, err_next;

   logic            addr_in_ram;
   logic            load_accept;
   logic            store_ram, store_led, store_bad;

   logic            ram_we;
   logic [AW-1:0]   ram_waddr;
   logic [15:0]     ram_wdata;
   logic [15:0]     fetch_word, data_word;

   ram64x16 #(.DEPTH(DEPTH)) u_ram (
      .clk         (Clock),
      .we          (ram_we),
      .waddr       (ram_waddr),
      .wdata       (ram_wdata),
      .raddr_fetch (bus.pc),
      .rdata_fetch (fetch_word),
      .raddr_data  (bus.addrM[AW-1:0]),
      .rdata_data  (data_word)
   );

   // Address decode and per-cycle transaction qualifiers.
   always_comb begin
      addr_in_ram = is_ram_addr(bus.addrM);
      load_accept = (state_reg == LOAD) && bus.load_valid;
      store_ram   = (state_reg == RUN) && bus.wM && addr_in_ram;
      store_led   = (state_reg == RUN) && bus.wM && !addr_in_ram && (bus.addrM == LED_ADDR);
      // The switch address is read-only, so a store there is also an error.
      store_bad   = (state_reg == RUN) && bus.wM && !addr_in_ram && (bus.addrM != LED_ADDR);
   end

   // Next-state logic for the CLEAR -> LOAD -> RUN sequence and its counters.
   always_comb begin
      state_next    = state_reg;
      clr_idx_next  = clr_idx_reg;
      load_ptr_next = load_ptr_reg;
      led_next      = led_reg;
      err_next      = err_reg;
      case (state_reg)
         CLEAR: begin
            clr_idx_next = clr_idx_reg + 1'b1;
            if (clr_idx_reg == LAST_IDX) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (load_accept) begin
               // Pointer saturates at the last word; the FSM leaves LOAD there anyway.
               if (load_ptr_reg != LAST_IDX) begin
                  load_ptr_next = load_ptr_reg + 1'b1;
               end
               if (bus.load_last || (load_ptr_reg == LAST_IDX)) begin
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            if (store_led) begin
               led_next = bus.doutM;
            end
            if (store_bad) begin
               err_next = 1'b1;
            end
         end
         default: begin
            state_next = CLEAR;
         end
      endcase
   end

   // The single RAM write port, steered by the current phase.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = clr_idx_reg;
      ram_wdata = 16'h0000;
      case (state_reg)
         CLEAR: begin
            ram_we = 1'b1;
         end
         LOAD: begin
            ram_we    = load_accept;
            ram_waddr = load_ptr_reg;
            ram_wdata = bus.load_data;
         end
         RUN: begin
            ram_we    = store_ram;
            ram_waddr = bus.addrM[AW-1:0];
            ram_wdata = bus.doutM;
         end
         default: begin
            ram_we = 1'b0;
         end
      endcase
   end

   // State and counter registers; reset restarts the clear pass from index 0.
   always_ff @(posedge Clock) begin
      if (Resetn) begin
         state_reg    <= CLEAR;
         clr_idx_reg  <= '0;
         load_ptr_reg <= '0;
         run_reg      <= 1'b0;
         led_reg      <= 16'h0000;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         clr_idx_reg  <= clr_idx_next;
         load_ptr_reg <= load_ptr_next;
         run_reg      <= (state_next == RUN);
         led_reg      <= led_next;
         err_reg      <= err_next;
      end
   end

   // Load-data mux over the memory map.
   always_comb begin
      if (addr_in_ram) begin
         bus.mem = data_word;
      end else if (bus.addrM == SW_ADDR) begin
         bus.mem = {6'b0, SW};
      end else begin
         bus.mem = 16'h0000;
      end
   end

   assign bus.DIN        = fetch_word;
   assign bus.Run        = run_reg;
   assign bus.load_ready = (state_reg == LOAD);
   assign LEDR           = led_reg;
   assign wr_err         = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: fixed scenarios plus randomized
// load/store traffic checked against a word-array model of the memory map.
module tb_mem_responder;
   import mem_map_pkg::*;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic [9:0]  SW;
   logic [15:0] LEDR;
   logic        wr_err;

   mem_responder_if bus();

   mem_responder dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (bus),
      .SW     (SW),
      .LEDR   (LEDR),
      .wr_err (wr_err)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;

   logic [15:0] model_ram [64];
   logic [15:0] model_led;
   logic        model_err;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic logic [15:0] exp_mem(input logic [15:0] a);
      if (a[15:6] == 10'd0) return model_ram[a[5:0]];
      if (a == SW_ADDR) return {6'b0, SW};
      return 16'h0000;
   endfunction

   task automatic idle_bus();
      bus.pc = '0; bus.addrM = 16'h0; bus.doutM = 16'h0; bus.wM = 1'b0;
      bus.load_valid = 1'b0; bus.load_data = 16'h0; bus.load_last = 1'b0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 64; i++) model_ram[i] = 16'h0000;
   endtask

   // Counts cycles from reset release until load_ready; Run must stay low.
   task automatic wait_clear(input string tag);
      int n = 0;
      bit run_seen = 0;
      while (bus.load_ready !== 1'b1 && n < 200) begin
         if (bus.Run !== 1'b0) run_seen = 1;
         tick();
         n++;
      end
      checks++;
      if (n != 64) begin
         errors++;
         $display("FAIL %s clear_cycles: got %0d expected 64", tag, n);
      end
      checks++;
      if (run_seen) begin
         errors++;
         $display("FAIL %s run_during_clear: got 1 expected 0", tag);
      end
   endtask

   // Every RAM word via both read ports against the model.
   task automatic sweep(input string tag);
      for (int i = 0; i < 64; i++) begin
         bus.pc = 6'(i);
         bus.addrM = 16'(i);
         #1;
         checks++;
         if (bus.DIN !== model_ram[i]) begin
            errors++;
            $display("FAIL %s din[%0d]: got %h expected %h", tag, i, bus.DIN, model_ram[i]);
         end
         checks++;
         if (bus.mem !== model_ram[i]) begin
            errors++;
            $display("FAIL %s mem[%0d]: got %h expected %h", tag, i, bus.mem, model_ram[i]);
         end
      end
      bus.pc = '0;
      bus.addrM = 16'h0;
   endtask

   task automatic test_reset();
      idle_bus();
      SW = 10'h0;
      Resetn = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready: got %b expected 0", bus.load_ready); end
      checks++;
      if (bus.Run !== 1'b0) begin errors++; $display("FAIL reset_run: got %b expected 0", bus.Run); end
      checks++;
      if (LEDR !== 16'h0) begin errors++; $display("FAIL reset_ledr: got %h expected 0000", LEDR); end
      checks++;
      if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b expected 0", wr_err); end
      model_led = 16'h0;
      model_err = 1'b0;
      // Stores while not running must be ignored.
      bus.wM = 1'b1;
      bus.addrM = 16'h3000;
      bus.doutM = 16'h5A5A;
      Resetn = 1'b0;
      wait_clear("reset");
      tick();
      tick();
      checks++;
      if (wr_err !== 1'b0) begin errors++; $display("FAIL store_outside_run_err: got %b expected 0", wr_err); end
      checks++;
      if (bus.Run !== 1'b0) begin errors++; $display("FAIL load_run: got %b expected 0", bus.Run); end
      bus.wM = 1'b0;
      model_clear();
      sweep("after_clear");
      $display("txn reset+clear done");
   endtask

   task automatic test_load();
      logic [15:0] words [3];
      words[0] = 16'h0040; words[1] = 16'h1234; words[2] = 16'hABCD;
      for (int i = 0; i < 3; i++) begin
         int gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            bus.load_valid = 1'b0;
            bus.load_data = 16'($urandom);
            bus.load_last = 1'($urandom);
            tick();
         end
         bus.load_valid = 1'b1;
         bus.load_data = words[i];
         bus.load_last = (i == 2);
         #1;
         checks++;
         if (bus.Run !== 1'b0) begin errors++; $display("FAIL load_run_early[%0d]: got %b expected 0", i, bus.Run); end
         tick();
         model_ram[i] = words[i];
         $display("txn load word %0d = %h", i, words[i]);
      end
      bus.load_valid = 1'b0;
      bus.load_last = 1'b0;
      checks++;
      if (bus.Run !== 1'b1) begin errors++; $display("FAIL load_run: got %b expected 1", bus.Run); end
      checks++;
      if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL run_load_ready: got %b expected 0", bus.load_ready); end
      bus.pc = 6'd1;
      #1;
      checks++;
      if (bus.DIN !== 16'h1234) begin errors++; $display("FAIL load_din1: got %h expected 1234", bus.DIN); end
   endtask

   task automatic test_store();
      bus.addrM = 16'd5; bus.doutM = 16'hBEEF; bus.wM = 1'b1; bus.pc = 6'd5;
      #1;
      checks++;
      if (bus.mem !== model_ram[5]) begin errors++; $display("FAIL store_old_mem: got %h expected %h", bus.mem, model_ram[5]); end
      tick();
      bus.wM = 1'b0;
      model_ram[5] = 16'hBEEF;
      #1;
      checks++;
      if (bus.mem !== 16'hBEEF) begin errors++; $display("FAIL store_new_mem: got %h expected beef", bus.mem); end
      checks++;
      if (bus.DIN !== 16'hBEEF) begin errors++; $display("FAIL store_new_din: got %h expected beef", bus.DIN); end
      bus.addrM = LED_ADDR; bus.doutM = 16'h00FF; bus.wM = 1'b1;
      tick();
      bus.wM = 1'b0;
      model_led = 16'h00FF;
      #1;
      checks++;
      if (LEDR !== 16'h00FF) begin errors++; $display("FAIL led_store: got %h expected 00ff", LEDR); end
      checks++;
      if (bus.mem !== 16'h0000) begin errors++; $display("FAIL led_readback: got %h expected 0000", bus.mem); end
      checks++;
      if (wr_err !== 1'b0) begin errors++; $display("FAIL led_wr_err: got %b expected 0", wr_err); end
      $display("txn store ram[5]=beef led=00ff");
   endtask

   task automatic test_sw_unmapped();
      SW = 10'h2A5;
      bus.addrM = SW_ADDR;
      #1;
      checks++;
      if (bus.mem !== 16'h02A5) begin errors++; $display("FAIL sw_read: got %h expected 02a5", bus.mem); end
      bus.addrM = 16'h3000; bus.doutM = 16'h5555; bus.wM = 1'b1;
      #1;
      checks++;
      if (wr_err !== 1'b0) begin errors++; $display("FAIL unmapped_err_pre: got %b expected 0", wr_err); end
      tick();
      bus.wM = 1'b0;
      model_err = 1'b1;
      checks++;
      if (wr_err !== 1'b1) begin errors++; $display("FAIL unmapped_err: got %b expected 1", wr_err); end
      checks++;
      if (LEDR !== model_led) begin errors++; $display("FAIL unmapped_ledr: got %h expected %h", LEDR, model_led); end
      sweep("unmapped");
      $display("txn store unmapped 3000");
   endtask

   task automatic test_random_run();
      for (int t = 0; t < 40; t++) begin
         logic [15:0] a;
         logic [9:0]  up;
         int kind = $urandom_range(0, 3);
         case (kind)
            0: a = 16'($urandom_range(0, 63));
            1: a = LED_ADDR;
            2: a = SW_ADDR;
            default: begin
               up = 10'($urandom_range(1, 1023));
               if (up == 10'h040 || up == 10'h080) up = up + 10'd1;
               a = {up, 6'($urandom)};
            end
         endcase
         SW = 10'($urandom);
         bus.addrM = a;
         bus.doutM = 16'($urandom);
         bus.wM = 1'($urandom);
         bus.pc = 6'($urandom);
         #1;
         checks++;
         if (bus.mem !== exp_mem(a)) begin errors++; $display("FAIL rnd_mem_pre[%0d]: got %h expected %h", t, bus.mem, exp_mem(a)); end
         checks++;
         if (bus.DIN !== model_ram[bus.pc]) begin errors++; $display("FAIL rnd_din[%0d]: got %h expected %h", t, bus.DIN, model_ram[bus.pc]); end
         tick();
         if (bus.wM) begin
            if (a[15:6] == 10'd0) model_ram[a[5:0]] = bus.doutM;
            else if (a == LED_ADDR) model_led = bus.doutM;
            else model_err = 1'b1;
         end
         $display("txn rnd %0d addr=%h data=%h w=%b", t, a, bus.doutM, bus.wM);
         bus.wM = 1'b0;
         #1;
         checks++;
         if (bus.mem !== exp_mem(a)) begin errors++; $display("FAIL rnd_mem_post[%0d]: got %h expected %h", t, bus.mem, exp_mem(a)); end
         checks++;
         if (LEDR !== model_led) begin errors++; $display("FAIL rnd_ledr[%0d]: got %h expected %h", t, LEDR, model_led); end
         checks++;
         if (wr_err !== model_err) begin errors++; $display("FAIL rnd_wr_err[%0d]: got %b expected %b", t, wr_err, model_err); end
      end
   endtask

   task automatic test_reset_mid_run();
      bus.addrM = LED_ADDR; bus.doutM = 16'h00FF; bus.wM = 1'b1;
      tick();
      bus.wM = 1'b0;
      checks++;
      if (LEDR !== 16'h00FF) begin errors++; $display("FAIL midrun_led_set: got %h expected 00ff", LEDR); end
      Resetn = 1'b1;
      bus.load_valid = 1'b1;
      bus.load_data = 16'hDEAD;
      tick();
      Resetn = 1'b0;
      bus.load_valid = 1'b0;
      model_led = 16'h0;
      model_err = 1'b0;
      checks++;
      if (LEDR !== 16'h0) begin errors++; $display("FAIL midrun_ledr: got %h expected 0000", LEDR); end
      checks++;
      if (bus.Run !== 1'b0) begin errors++; $display("FAIL midrun_run: got %b expected 0", bus.Run); end
      checks++;
      if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL midrun_load_ready: got %b expected 0", bus.load_ready); end
      checks++;
      if (wr_err !== 1'b0) begin errors++; $display("FAIL midrun_wr_err: got %b expected 0", wr_err); end
      wait_clear("midrun");
      model_clear();
      sweep("midrun_clear");
      $display("txn reset mid-run");
   endtask

   task automatic test_overflow_load();
      int acc = 0;
      for (int k = 0; k < 70; k++) begin
         bus.load_valid = 1'b1;
         bus.load_data = 16'($urandom);
         bus.load_last = 1'b0;
         #1;
         if (k == 64) begin
            checks++;
            if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready65: got %b expected 0", bus.load_ready); end
            checks++;
            if (bus.Run !== 1'b1) begin errors++; $display("FAIL ovf_run65: got %b expected 1", bus.Run); end
         end
         if (bus.load_ready === 1'b1) acc++;
         if (k < 64) model_ram[k] = bus.load_data;
         tick();
      end
      bus.load_valid = 1'b0;
      checks++;
      if (acc != 64) begin errors++; $display("FAIL ovf_accepted: got %0d expected 64", acc); end
      checks++;
      if (bus.Run !== 1'b1) begin errors++; $display("FAIL ovf_run: got %b expected 1", bus.Run); end
      checks++;
      if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b expected 0", bus.load_ready); end
      sweep("overflow");
      $display("txn stream 70 words");
   endtask

   task automatic test_sw_store();
      SW = 10'h155;
      bus.addrM = SW_ADDR; bus.doutM = 16'h1234; bus.wM = 1'b1;
      tick();
      bus.wM = 1'b0;
      #1;
      checks++;
      if (wr_err !== 1'b1) begin errors++; $display("FAIL sw_store_err: got %b expected 1", wr_err); end
      checks++;
      if (bus.mem !== 16'h0155) begin errors++; $display("FAIL sw_store_mem: got %h expected 0155", bus.mem); end
      checks++;
      if (LEDR !== 16'h0) begin errors++; $display("FAIL sw_store_ledr: got %h expected 0000", LEDR); end
      $display("txn store to switch address");
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_sw_unmapped();
      test_random_run();
      test_reset_mid_run();
      test_overflow_load();
      test_sw_store();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, the number of 16-bit RAM words (word address width 6).
REQ-002 SHALL have parameter LED_ADDR, default 16'h1000, the write address of the LED register.
REQ-003 SHALL have parameter SW_ADDR, default 16'h2000, the read address of the switch inputs.
REQ-004 SHALL have port Clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Resetn, input, 1, the reset; it is synchronous and active-high despite the name.
REQ-006 SHALL have port pc, input, 6, the instruction fetch word address.
REQ-007 SHALL have port DIN, output, 16, the instruction word at pc.
REQ-008 SHALL have port addrM, input, 16, the data access address.
REQ-009 SHALL have port doutM, input, 16, the store data.
REQ-010 SHALL have port wM, input, 1, the store strobe.
REQ-011 SHALL have port mem, output, 16, the load data at addrM.
REQ-012 SHALL have port Run, output, 1, the processor enable; high only in state RUN.
REQ-013 SHALL have ports load_valid (input, 1), load_data (input, 16), load_last (input, 1) and load_ready (output, 1), forming the program loader handshake.
REQ-014 SHALL have port SW, input, 10, the switch inputs.
REQ-015 SHALL have port LEDR, output, 16, the LED register.
REQ-016 SHALL have port wr_err, output, 1, a sticky flag set by a store to an unmapped address.

Function
REQ-017 SHALL implement the FSM states CLEAR, LOAD and RUN; reset enters CLEAR.
REQ-018 CLEAR SHALL write 0 to RAM[clr_idx] every cycle with clr_idx counting 0..63; after the write of index 63 it SHALL move to LOAD (64 cycles in CLEAR).
REQ-019 In LOAD, load_ready SHALL be 1; a word is accepted on an edge where load_valid&load_ready, written to RAM[load_ptr], and load_ptr increments.
REQ-020 LOAD SHALL move to RUN after accepting a word with load_last=1, or after accepting the word at load_ptr=63, whichever comes first; load_ptr SHALL never wrap.
REQ-021 load_valid while not in LOAD SHALL be ignored, and load_ready SHALL be 0 in CLEAR and RUN.
REQ-022 Run SHALL be registered, rising in the first cycle the FSM is in RUN.
REQ-023 RUN SHALL be left only by reset.
REQ-024 DIN SHALL be the combinational read RAM[pc] in every state.
REQ-025 mem SHALL be the combinational read: RAM[addrM[5:0]] when addrM[15:6]==0; {6'b0,SW} when addrM==SW_ADDR; 16'h0000 otherwise.
REQ-026 In RUN with wM=1, on the edge: if addrM[15:6]==0 then RAM[addrM[5:0]]<=doutM; if addrM==LED_ADDR then LEDR<=doutM; otherwise no state change and wr_err<=1.
REQ-027 wM outside RUN SHALL be ignored and SHALL NOT set wr_err.
REQ-028 Read-during-write: DIN and mem SHALL show the old word before the edge and the new word after it, with no bypass.
REQ-029 A store to SW_ADDR SHALL count as unmapped and set wr_err.
REQ-030 The RAM SHALL have exactly one write port, muxed by state: CLEAR writes zero, LOAD writes load_data, RUN writes doutM.

Reset
REQ-031 On an edge with Resetn=1 the block SHALL set: state CLEAR, clr_idx 0, load_ptr 0, Run 0, load_ready 0, LEDR 0, wr_err 0.
REQ-032 Reset SHALL NOT clear the RAM directly; RAM contents are cleared by the subsequent CLEAR pass.
REQ-033 Reset asserted mid-LOAD or mid-RUN SHALL drop Run and load_ready the next cycle and restart CLEAR from index 0.
REQ-034 A load word presented in the same cycle as reset SHALL NOT be accepted.

Structure
REQ-035 A shared package mem_map_pkg SHALL hold DEPTH, LED_ADDR, SW_ADDR and the state encoding (CLEAR=2'd0, LOAD=2'd1, RUN=2'd2).
REQ-036 The block SHALL have one sub-module, ram64x16: 64x16 storage with two asynchronous read ports (fetch, data) and one synchronous write port.
REQ-037 The FSM, counters and address decode SHALL reside in mem_responder.

Verification
REQ-038 Bench: reset, then hold load_valid=0 -> load_ready rises exactly 64 cycles after reset deasserts, Run=0, and DIN=0 for all pc.
REQ-039 Bench: load 3 words 16'h0040, 16'h1234, 16'hABCD with load_last on the third -> Run=1 next cycle; pc=1 gives DIN=16'h1234.
REQ-040 Bench: in RUN, wM=1, addrM=5, doutM=16'hBEEF -> mem=16'hBEEF after the edge; then addrM=LED_ADDR, doutM=16'h00FF -> LEDR=16'h00FF.
REQ-041 Bench: SW=10'h2A5, addrM=SW_ADDR -> mem=16'h02A5; a store to 16'h3000 -> wr_err=1, RAM and LEDR unchanged.
REQ-042 Bench: stream 70 words without load_last -> exactly 64 accepted, load_ready=0 from the 65th cycle, Run=1.
REQ-043 Bench: reset pulsed mid-RUN with LEDR=16'h00FF -> LEDR=0, Run=0, and a new 64-cycle CLEAR after which every RAM word reads 0.
